// File: rtl/qerv_rf_arbiter_pkg.sv
// Shared types for the RF RAM arbiter: FSM state encoding and its width.
package qerv_rf_arb_pkg;

   localparam int unsigned ArbStateW = 3;

   typedef enum logic [ArbStateW-1:0] {
      StIdle,
      StCore,
      StDbg,
      StRsp,
      StAck
   } arb_state_e;

endpackage

// File: rtl/qerv_rf_arbiter_if.sv
// Debug register peek/poke port of the RF arbiter: held request, one-cycle ack.
interface qerv_rf_arbiter_if #(
   parameter int unsigned RF_WIDTH = 2,
   parameter int unsigned RF_L2D   = 8
);
   logic                req;
   logic                we;
   logic [RF_L2D-1:0]   addr;
   logic [RF_WIDTH-1:0] wdata;
   logic                ack;
   logic [RF_WIDTH-1:0] rdata;

   modport master (
      output req, we, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/qerv_rf_arbiter.sv
// RF RAM port arbiter: core windows pass through, single-word debug accesses slot in between.
// Define QERV_RF_ARB_STATS_EN to add debug-ack and core-hold statistics counters.
module qerv_rf_arbiter
   import qerv_rf_arb_pkg::*;
#(
   parameter int unsigned RF_WIDTH     = 2,
   parameter int unsigned RF_L2D       = 8,
   parameter int unsigned DBG_MAX_WAIT = 16
) (
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic                i_core_rreq,
   input  logic                i_core_wreq,
   output logic                o_core_rreq,
   output logic                o_core_wreq,
   input  logic                i_ifc_ready,
   input  logic [RF_L2D-1:0]   i_ifc_waddr,
   input  logic [RF_WIDTH-1:0] i_ifc_wdata,
   input  logic                i_ifc_wen,
   input  logic [RF_L2D-1:0]   i_ifc_raddr,
   input  logic                i_ifc_ren,
   output logic [RF_L2D-1:0]   o_ram_waddr,
   output logic [RF_WIDTH-1:0] o_ram_wdata,
   output logic                o_ram_wen,
   output logic [RF_L2D-1:0]   o_ram_raddr,
   output logic                o_ram_ren,
   input  logic [RF_WIDTH-1:0] i_ram_rdata,
   qerv_rf_arbiter_if.slave    dbg
`ifdef QERV_RF_ARB_STATS_EN
   ,
   output logic [15:0]         o_stat_dbg_cnt,
   output logic [15:0]         o_stat_hold_cnt
`endif
);

   localparam int unsigned CntW = $clog2(DBG_MAX_WAIT + 1);
   localparam logic [CntW-1:0] WaitMax = CntW'(DBG_MAX_WAIT);

   arb_state_e          state_q, state_d;
   logic [CntW-1:0]     wait_q, wait_d;
   logic                pend_r_q, pend_r_d;
   logic                pend_w_q, pend_w_d;
   logic                rdy_seen_q, rdy_seen_d;
   logic                cmd_we_q, cmd_we_d;
   logic [RF_L2D-1:0]   cmd_addr_q, cmd_addr_d;
   logic [RF_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [RF_WIDTH-1:0] rdata_q, rdata_d;

   logic req_r, req_w, dbg_phase, hold, ack;

   assign req_r     = i_core_rreq | pend_r_q;
   assign req_w     = i_core_wreq | pend_w_q;
   assign dbg_phase = (state_q == StDbg) || (state_q == StRsp) || (state_q == StAck);
   // Aged debug request: core may not start a new window until debug is served.
   assign hold      = (wait_q == WaitMax) && dbg.req;

   always_comb begin
      state_d     = state_q;
      wait_d      = wait_q;
      pend_r_d    = pend_r_q | i_core_rreq;
      pend_w_d    = pend_w_q | i_core_wreq;
      rdy_seen_d  = rdy_seen_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata_d     = rdata_q;
      o_core_rreq = 1'b0;
      o_core_wreq = 1'b0;
      o_ram_waddr = '0;
      o_ram_wdata = '0;
      o_ram_wen   = 1'b0;
      o_ram_raddr = '0;
      o_ram_ren   = 1'b0;
      ack         = 1'b0;

      if (dbg.req && !dbg_phase && (wait_q != WaitMax)) begin
         wait_d = wait_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if ((req_r || req_w) && !hold) begin
               // Gated by reset so the combinational forward path is quiet in reset.
               o_core_rreq = req_r & i_rst_n;
               o_core_wreq = req_w & i_rst_n;
               pend_r_d    = 1'b0;
               pend_w_d    = 1'b0;
               rdy_seen_d  = 1'b0;
               state_d     = StCore;
            end else if (dbg.req) begin
               cmd_we_d    = dbg.we;
               cmd_addr_d  = dbg.addr;
               cmd_wdata_d = dbg.wdata;
               state_d     = StDbg;
            end
         end
         StCore: begin
            o_ram_waddr = i_ifc_waddr;
            o_ram_wdata = i_ifc_wdata;
            o_ram_wen   = i_ifc_wen;
            o_ram_raddr = i_ifc_raddr;
            o_ram_ren   = i_ifc_ren;
            if (i_ifc_ready) begin
               rdy_seen_d = 1'b1;
            end
            if ((rdy_seen_q || i_ifc_ready) && !i_ifc_ren && !i_ifc_wen) begin
               state_d = StIdle;
            end
         end
         StDbg: begin
            o_ram_waddr = cmd_addr_q;
            o_ram_wdata = cmd_wdata_q;
            o_ram_raddr = cmd_addr_q;
            if (cmd_we_q) begin
               o_ram_wen = 1'b1;
               state_d   = StAck;
            end else begin
               o_ram_ren = 1'b1;
               state_d   = StRsp;
            end
         end
         StRsp: begin
            rdata_d = i_ram_rdata;
            state_d = StAck;
         end
         StAck: begin
            ack     = 1'b1;
            wait_d  = '0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         pend_r_q    <= 1'b0;
         pend_w_q    <= 1'b0;
         rdy_seen_q  <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         pend_r_q    <= pend_r_d;
         pend_w_q    <= pend_w_d;
         rdy_seen_q  <= rdy_seen_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
      end
   end

   assign dbg.ack   = ack;
   assign dbg.rdata = rdata_q;

`ifdef QERV_RF_ARB_STATS_EN
   logic [15:0] stat_dbg_q, stat_dbg_d;
   logic [15:0] stat_hold_q, stat_hold_d;
   logic        core_held;

   assign core_held = (state_q == StIdle) && hold && (req_r || req_w);

   always_comb begin
      stat_dbg_d  = stat_dbg_q + 16'(ack);
      stat_hold_d = stat_hold_q;
      if (core_held && (stat_hold_q != 16'hffff)) begin
         stat_hold_d = stat_hold_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stat_dbg_q  <= '0;
         stat_hold_q <= '0;
      end else begin
         stat_dbg_q  <= stat_dbg_d;
         stat_hold_q <= stat_hold_d;
      end
   end

   assign o_stat_dbg_cnt  = stat_dbg_q;
   assign o_stat_hold_cnt = stat_hold_q;
`endif

`ifndef SYNTHESIS
   // The interface must only drive the RAM inside a granted core window.
   ifc_en_outside_core: assert property (@(posedge clk) disable iff (!i_rst_n)
      (state_q != StCore) |-> !(i_ifc_ren || i_ifc_wen));
`endif

endmodule

// File: tb/tb_qerv_rf_arbiter.sv
// Self-checking bench for qerv_rf_arbiter: directed timing cases plus randomized traffic
// scored against a RAM scoreboard and request/ack accounting.
module tb_qerv_rf_arbiter;

   localparam int unsigned RF_WIDTH     = 2;
   localparam int unsigned RF_L2D       = 8;
   localparam int unsigned DBG_MAX_WAIT = 16;
   localparam int unsigned Bound        = 30;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                i_core_rreq, i_core_wreq;
   logic                o_core_rreq, o_core_wreq;
   logic                i_ifc_ready;
   logic [RF_L2D-1:0]   i_ifc_waddr, i_ifc_raddr;
   logic [RF_WIDTH-1:0] i_ifc_wdata;
   logic                i_ifc_wen, i_ifc_ren;
   logic [RF_L2D-1:0]   o_ram_waddr, o_ram_raddr;
   logic [RF_WIDTH-1:0] o_ram_wdata;
   logic                o_ram_wen, o_ram_ren;
   logic [RF_WIDTH-1:0] ram_rdata;
`ifdef QERV_RF_ARB_STATS_EN
   logic [15:0]         stat_dbg, stat_hold;
`endif

   always #5 clk = ~clk;

   qerv_rf_arbiter_if #(.RF_WIDTH(RF_WIDTH), .RF_L2D(RF_L2D)) dbg_if ();

   qerv_rf_arbiter #(
      .RF_WIDTH    (RF_WIDTH),
      .RF_L2D      (RF_L2D),
      .DBG_MAX_WAIT(DBG_MAX_WAIT)
   ) dut (
      .clk        (clk),
      .i_rst_n    (rst_n),
      .i_core_rreq(i_core_rreq),
      .i_core_wreq(i_core_wreq),
      .o_core_rreq(o_core_rreq),
      .o_core_wreq(o_core_wreq),
      .i_ifc_ready(i_ifc_ready),
      .i_ifc_waddr(i_ifc_waddr),
      .i_ifc_wdata(i_ifc_wdata),
      .i_ifc_wen  (i_ifc_wen),
      .i_ifc_raddr(i_ifc_raddr),
      .i_ifc_ren  (i_ifc_ren),
      .o_ram_waddr(o_ram_waddr),
      .o_ram_wdata(o_ram_wdata),
      .o_ram_wen  (o_ram_wen),
      .o_ram_raddr(o_ram_raddr),
      .o_ram_ren  (o_ram_ren),
      .i_ram_rdata(ram_rdata),
      .dbg        (dbg_if.slave)
`ifdef QERV_RF_ARB_STATS_EN
      ,
      .o_stat_dbg_cnt (stat_dbg),
      .o_stat_hold_cnt(stat_hold)
`endif
   );

   // Behavioural RAM with one-cycle read latency.
   logic [RF_WIDTH-1:0] ram [256];
   always @(posedge clk) begin
      if (o_ram_wen) ram[o_ram_waddr] <= o_ram_wdata;
      if (o_ram_ren) ram_rdata <= ram[o_ram_raddr];
   end

   int unsigned n_vec = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic clr_inputs();
      i_core_rreq = 0; i_core_wreq = 0; i_ifc_ready = 0;
      i_ifc_waddr = '0; i_ifc_wdata = '0; i_ifc_wen = 0;
      i_ifc_raddr = '0; i_ifc_ren = 0;
      dbg_if.req = 0; dbg_if.we = 0; dbg_if.addr = '0; dbg_if.wdata = '0;
   endtask

   task automatic dbg_set(input logic we, input logic [RF_L2D-1:0] a, input logic [RF_WIDTH-1:0] d);
      dbg_if.req = 1; dbg_if.we = we; dbg_if.addr = a; dbg_if.wdata = d;
   endtask

   // Scoreboard state for the randomized phase.
   logic [RF_WIDTH-1:0] ref_mem [256];
   bit                  ref_ok  [256];
   int                  exp_r = 0, exp_w = 0, ifc_cnt = 0, dbg_wait = 0;
   bit                  ifc_wr = 0, core_busy = 0, dbg_busy = 0;

   task automatic rand_cycle(input int unsigned core_p, input int unsigned dbg_p);
      logic [RF_L2D-1:0] a;
      next_cyc();
      i_core_rreq = 0; i_core_wreq = 0;
      i_ifc_ren = 0; i_ifc_wen = 0; i_ifc_ready = 0;
      if (ifc_cnt > 0) begin
         if (ifc_wr) begin
            i_ifc_wen   = 1;
            i_ifc_waddr = 8'($urandom_range(7));
            i_ifc_wdata = 2'($urandom);
            ref_mem[i_ifc_waddr] = i_ifc_wdata;
            ref_ok[i_ifc_waddr]  = 1;
         end else begin
            i_ifc_ren   = 1;
            i_ifc_raddr = 8'($urandom_range(7));
         end
         i_ifc_ready = (ifc_cnt == 1);
         ifc_cnt--;
         if (ifc_cnt == 0) core_busy = 0;
      end else if (!core_busy && ($urandom_range(99) < core_p)) begin
         core_busy = 1;
         if ($urandom_range(1) == 1) begin i_core_wreq = 1; exp_w++; end
         else begin i_core_rreq = 1; exp_r++; end
      end
      if (!dbg_busy && ($urandom_range(99) < dbg_p)) begin
         dbg_busy = 1;
         dbg_wait = 0;
         dbg_set(1'($urandom_range(1)), 8'($urandom_range(7)), 2'($urandom));
      end
      dbg_if.req = dbg_busy;
      smp();
      if (o_core_rreq) begin
         check("rreq_fwd_legal", exp_r != 0, 1);
         if (exp_r > 0) exp_r--;
         ifc_cnt = 1 + $urandom_range(2);
         ifc_wr  = 0;
      end
      if (o_core_wreq) begin
         check("wreq_fwd_legal", exp_w != 0, 1);
         if (exp_w > 0) exp_w--;
         ifc_cnt = 1 + $urandom_range(2);
         ifc_wr  = 1;
      end
      if (dbg_if.ack) begin
         check("ack_legal", dbg_busy, 1);
         if (dbg_busy) begin
            a = dbg_if.addr;
            check("dbg_wait_ok", dbg_wait <= Bound, 1);
            if (dbg_if.we) begin
               ref_mem[a] = dbg_if.wdata;
               ref_ok[a]  = 1;
            end else if (ref_ok[a]) begin
               check("dbg_rdata", dbg_if.rdata, ref_mem[a]);
            end
         end
         dbg_busy = 0;
      end else if (dbg_busy) begin
         dbg_wait++;
         if (dbg_wait > Bound) begin
            check("dbg_wait_ok", dbg_wait <= Bound, 1);
            dbg_busy = 0;
         end
      end
   endtask

   int fwd_at[$];
   int ack_at, npulse;
   int rd_win;
   bit pulse_next;

   initial begin
      clr_inputs();
      rst_n = 0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      smp();
      check("rst_ack", dbg_if.ack, 0);
      check("rst_rdata", dbg_if.rdata, 0);
      check("rst_ram_wen", o_ram_wen, 0);
      check("rst_ram_ren", o_ram_ren, 0);
      check("rst_core_rreq", o_core_rreq, 0);
      check("rst_core_wreq", o_core_wreq, 0);

      // Debug write 0x05 <= 2'b10: RAM write at +1, ack at +2.
      next_cyc(); dbg_set(1, 8'h05, 2'b10); smp();
      check("wr_ack_c0", dbg_if.ack, 0);
      next_cyc(); smp();
      check("wr_wen_c1", o_ram_wen, 1);
      check("wr_waddr_c1", o_ram_waddr, 8'h05);
      check("wr_wdata_c1", o_ram_wdata, 2'b10);
      check("wr_ack_c1", dbg_if.ack, 0);
      next_cyc(); smp();
      check("wr_ack_c2", dbg_if.ack, 1);
      next_cyc(); dbg_if.req = 0; smp();

      // Debug read 0x05: RAM read at +1, ack with data at +3.
      next_cyc(); dbg_set(0, 8'h05, 2'b00); smp();
      next_cyc(); smp();
      check("rd_ren_c1", o_ram_ren, 1);
      check("rd_raddr_c1", o_ram_raddr, 8'h05);
      next_cyc(); smp();
      check("rd_ack_c2", dbg_if.ack, 0);
      next_cyc(); smp();
      check("rd_ack_c3", dbg_if.ack, 1);
      check("rd_data_c3", dbg_if.rdata, 2'b10);
      next_cyc(); dbg_if.req = 0; smp();

      // Core rreq during the DBG cycle is deferred to the IDLE cycle after ACK, once.
      npulse = 0;
      next_cyc(); dbg_set(1, 8'h03, 2'b01); smp();
      for (int c = 1; c <= 6; c++) begin
         next_cyc();
         i_core_rreq = (c == 1);
         dbg_if.req  = (c <= 2);
         i_ifc_ren   = (c == 4);
         i_ifc_ready = (c == 4);
         smp();
         if (c == 2) check("defer_ack", dbg_if.ack, 1);
         if (c == 3) check("defer_fwd_c3", o_core_rreq, 1);
         if (o_core_rreq) npulse++;
      end
      check("defer_fwd_once", npulse, 1);
      clr_inputs();
`ifdef QERV_RF_ARB_STATS_EN
      check("stat_dbg_3", stat_dbg, 3);
`endif

      // Simultaneous core and debug request with a fresh counter: core first.
      ack_at = -1; npulse = 0;
      next_cyc(); i_core_rreq = 1; dbg_set(1, 8'h06, 2'b11); smp();
      check("sim_core_fwd", o_core_rreq, 1);
      for (int c = 1; c <= 8; c++) begin
         next_cyc();
         i_core_rreq = 0;
         i_ifc_ren   = (c == 1) || (c == 2);
         i_ifc_ready = (c == 2);
         dbg_if.req  = (ack_at < 0);
         smp();
         if (dbg_if.ack) ack_at = c;
         if (o_core_rreq) npulse++;
      end
      check("sim_dbg_ack_at", ack_at, 6);
      check("sim_no_refwd", npulse, 0);
      clr_inputs();

      // Back-to-back core traffic while a debug read ages to DBG_MAX_WAIT.
      ack_at = -1; rd_win = 0; pulse_next = 0;
      fwd_at.delete();
      for (int c = 0; c < 28; c++) begin
         next_cyc();
         i_core_rreq = (c == 0) || pulse_next;
         pulse_next  = 0;
         i_ifc_ren   = 0;
         i_ifc_ready = 0;
         if (rd_win > 0) begin
            i_ifc_ren   = 1;
            i_ifc_ready = (rd_win == 1);
            if ((rd_win == 1) && (ack_at < 0)) pulse_next = 1;
            rd_win--;
         end
         if (ack_at < 0) dbg_set(0, 8'h05, 2'b00);
         else dbg_if.req = 0;
         smp();
         if (o_core_rreq) begin
            fwd_at.push_back(c);
            rd_win = 2;
         end
         if (dbg_if.ack) begin
            ack_at = c;
            check("sat_rdata", dbg_if.rdata, 2'b10);
         end
      end
      check("sat_ack_at", ack_at, 19);
      check("sat_fwd_cnt", fwd_at.size(), 5);
      if (fwd_at.size() == 5) begin
         check("sat_last_pre", fwd_at[3], 12);
         check("sat_held_fwd", fwd_at[4], 20);
      end
`ifdef QERV_RF_ARB_STATS_EN
      check("stat_hold_nz", stat_hold != 0, 1);
`endif
      clr_inputs();

      // Reset in the RSP cycle aborts the access without an ack.
      next_cyc(); dbg_set(0, 8'h05, 2'b00); smp();
      next_cyc(); smp();
      check("rst_mid_ren", o_ram_ren, 1);
      next_cyc();
      #2 rst_n = 0; dbg_if.req = 0;
      #1;
      check("rst_mid_ack", dbg_if.ack, 0);
      check("rst_mid_rdata", dbg_if.rdata, 0);
      check("rst_mid_ren0", o_ram_ren, 0);
      check("rst_mid_wen0", o_ram_wen, 0);
      next_cyc(); rst_n = 1;
      npulse = 0;
      for (int c = 0; c < 4; c++) begin
         smp();
         if (dbg_if.ack || o_ram_wen || o_ram_ren) npulse++;
         next_cyc();
      end
      check("rst_no_activity", npulse, 0);
`ifdef QERV_RF_ARB_STATS_EN
      check("stat_rst", stat_dbg, 0);
`endif
      dbg_set(1, 8'h07, 2'b01); smp();
      next_cyc(); smp();
      check("post_rst_wen", o_ram_wen, 1);
      next_cyc(); smp();
      check("post_rst_ack", dbg_if.ack, 1);
      next_cyc(); clr_inputs(); smp();

      // Randomized traffic in three mixes.
      for (int i = 0; i < 256; i++) ref_ok[i] = 0;
      for (int i = 0; i < 1000; i++) rand_cycle(30, 30);
      for (int i = 0; i < 1000; i++) rand_cycle(100, 20);
      for (int i = 0; i < 1000; i++) rand_cycle(10, 80);
      for (int i = 0; i < 200; i++) begin
         if (!core_busy && !dbg_busy && (ifc_cnt == 0)) break;
         rand_cycle(0, 0);
      end
      check("rreq_all_fwd", exp_r, 0);
      check("wreq_all_fwd", exp_w, 0);
      check("dbg_all_acked", dbg_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
